sr_mdu_issue: RTL and testbench
===============================

# sr_mdu_issue

CPU-side issue and stall controller for the multi-cycle multiply/divide unit. It accepts one MDU instruction at a time from the decode stage and registers its operands and destination. It drives the MDU request port and holds the opcode stable until the result returns. It stalls the core for the whole operation, then delivers a one-cycle writeback. Flushes, unsupported opcodes and a lost result (timeout) are all handled here.

## Interface
- `MUL_LATENCY`, default 2: expected MDU multiply latency in cycles; legal range 1 ≤ MUL_LATENCY < TIMEOUT.
- `TIMEOUT`, default 16: maximum cycles spent in WAIT before the operation is aborted.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_vld`  in  1  decode stage presents an MDU instruction; held while `stall`=1.
- `req_op`  in  3  MDU opcode; 3'b000 = MUL, all others unsupported.
- `req_a`, `req_b`  in  32  operands.
- `req_rd`  in  5  destination register.
- `flush`  in  1  pipeline flush; kills any in-flight operation.
- `stall`  out  1  freeze the core.
- `wb_vld`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  5  writeback destination.
- `wb_data`  out  32  writeback data.
- `err_illegal`  out  1  pulse: unsupported opcode presented.
- `err_timeout`  out  1  pulse: MDU result never arrived.
- `mdu_srcA`, `mdu_srcB`  out  32  registered operands to the MDU.
- `mdu_src_vld`  out  1  one-cycle issue strobe.
- `mdu_src_clear`  out  1  abort strobe to the MDU pipeline.
- `mdu_op`  out  3  registered opcode, held from ISSUE through WAIT.
- `mdu_result`  in  32  MDU result.
- `mdu_result_vld`  in  1  MDU result valid; combinational on the MDU side and qualified by `mdu_op`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- All registers reset to 0. With no `req_vld`, every output is 0 in reset.
- **IDLE**
  - If `req_vld` & op==MUL & !`flush`: capture a, b, op, rd and go to ISSUE. `stall`=1 in this cycle.
  - If `req_vld` & op unsupported & !`flush`: `err_illegal`=1 (combinational), `stall`=0, no state change, no writeback.
- **ISSUE**
  - `mdu_src_vld`=1 with the registered operands. Go to WAIT and clear the timeout counter.
- **WAIT**
  - `mdu_op` stays held; the counter increments each cycle.
  - On `mdu_result_vld`: capture `mdu_result` into the `wb_data` register and go to DONE.
  - If the counter reaches TIMEOUT-1 without `mdu_result_vld`: `mdu_src_clear`=1 for that cycle, set a sticky timeout flag, go to DONE.
- **DONE**
  - `stall`=0.
  - `wb_vld`=1 only if no timeout occurred; `err_timeout`=1 if it did.
  - Always return to IDLE. `req_vld` is ignored in DONE, because the held instruction retires this cycle.
- **flush**
  - Highest priority in every state.
  - In ISSUE or WAIT: `mdu_src_clear`=1 that cycle, `mdu_src_vld` suppressed, next state IDLE, no writeback, no error.
  - In DONE: `wb_vld` and `err_timeout` are suppressed.
  - Flush wins over a simultaneous `mdu_result_vld`.
- **stall** = (state ∈ {ISSUE, WAIT}) | (IDLE & `req_vld` & op==MUL & !`flush`).
- `mdu_op` drives 3'b111 (no-op) in IDLE and DONE so that `mdu_result_vld` is masked.
- Counter width is $clog2(TIMEOUT+1).
- Reset asserted mid-operation forces IDLE immediately; no `mdu_src_clear` is generated (the MDU shares `reset_n`).

## Timing
- Accept at cycle T → `mdu_src_vld` at T+1 → `mdu_result_vld` at T+1+MUL_LATENCY → `wb_vld` at T+2+MUL_LATENCY.
- `stall` is high from T through T+1+MUL_LATENCY, i.e. MUL_LATENCY+2 stall cycles.
- Back-to-back throughput: the next instruction can be accepted at T+3+MUL_LATENCY, one cycle after DONE.
- Timeout: `mdu_src_clear` at T+1+TIMEOUT, `err_timeout` at T+2+TIMEOUT.
- `wb_*`, `err_timeout`, `mdu_src*` and `mdu_op` come from registered state. `stall`, `err_illegal` and `mdu_src_clear` on flush are combinational.

## Structure
- Shared package `sr_mdu_pkg`:
  - op enum: MDU_OP_MUL=3'b000, MDU_OP_NONE=3'b111.
  - FSM state enum.
  - `mdu_req_t` struct {a, b, op, rd}.
- Single module, no sub-module.
- Elaboration-time assertion that MUL_LATENCY ≥ 1 and MUL_LATENCY < TIMEOUT.

## Test plan
- MUL 7×6, rd=5, MUL_LATENCY=2, req at T → `stall` high for T..T+3; `wb_vld` at T+4 with `wb_rd`=5 and `wb_data`=42; exactly one `mdu_src_vld`.
- Two back-to-back MULs 0xFFFF_FFFF×2 then 3×3 → `wb_data` 0xFFFF_FFFE then 9; second `mdu_src_vld` exactly 5 cycles after the first.
- req_op=3'b001 → `err_illegal`=1 for one cycle, `stall`=0, no `mdu_src_vld`, no `wb_vld`.
- `flush` in the WAIT cycle coinciding with `mdu_result_vld` → `mdu_src_clear`=1, no `wb_vld`, IDLE next cycle, following MUL completes normally.
- MDU model never returns a result, TIMEOUT=16 → `mdu_src_clear` at T+17, `err_timeout` at T+18, `wb_vld` stays 0.
- `reset_n` dropped during WAIT → all outputs 0 asynchronously; after release, a new MUL 5×5 writes back 25.

Source files
------------

// File: rtl/sr_mdu_pkg.sv
// Shared types for the MDU issue controller.
// Opcodes, FSM states and the captured request bundle.
package sr_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_OP_MUL  = 3'b000,
    MDU_OP_NONE = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
  } mdu_req_t;

endpackage

// File: rtl/sr_mdu_issue_if.sv
// Decode / writeback / MDU-port bundle of sr_mdu_issue.
// slave = issue controller view, master = core + MDU side.
interface sr_mdu_issue_if;

  logic        req_vld;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall;
  logic        wb_vld;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_illegal;
  logic        err_timeout;
  logic [31:0] mdu_srcA;
  logic [31:0] mdu_srcB;
  logic        mdu_src_vld;
  logic        mdu_src_clear;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_result;
  logic        mdu_result_vld;

  modport slave (
    input  req_vld, req_op, req_a, req_b, req_rd,
    input  flush, mdu_result, mdu_result_vld,
    output stall, wb_vld, wb_rd, wb_data,
    output err_illegal, err_timeout,
    output mdu_srcA, mdu_srcB, mdu_src_vld,
    output mdu_src_clear, mdu_op
  );

  modport master (
    output req_vld, req_op, req_a, req_b, req_rd,
    output flush, mdu_result, mdu_result_vld,
    input  stall, wb_vld, wb_rd, wb_data,
    input  err_illegal, err_timeout,
    input  mdu_srcA, mdu_srcB, mdu_src_vld,
    input  mdu_src_clear, mdu_op
  );

endinterface

// File: rtl/sr_mdu_issue.sv
// MDU issue/stall controller: IDLE->ISSUE->WAIT->DONE.
// Ports: clk, reset_n (async low), bus (sr_mdu_issue_if.slave).
module sr_mdu_issue
  import sr_mdu_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic clk,
  input  logic reset_n,
  sr_mdu_issue_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  if (MUL_LATENCY < 1 || MUL_LATENCY >= TIMEOUT) begin : g_bad_cfg
    $error("sr_mdu_issue: need 1 <= MUL_LATENCY < TIMEOUT");
  end

  mdu_state_e     state_q, state_d;
  mdu_req_t       req_q, req_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tmo_q, tmo_d;
  logic [31:0]    wdat_q, wdat_d;

  logic is_mul;
  logic accept;
  logic busy;
  logic tmo_hit;

  assign is_mul  = (bus.req_op == MDU_OP_MUL);
  assign accept  = (state_q == ST_IDLE) & bus.req_vld
                 & is_mul & ~bus.flush;
  assign busy    = (state_q == ST_ISSUE)
                 | (state_q == ST_WAIT);
  assign tmo_hit = (state_q == ST_WAIT)
                 & ~bus.mdu_result_vld
                 & (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    wdat_d  = wdat_q;
    if (bus.flush && busy) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d  = ST_ISSUE;
            req_d.a  = bus.req_a;
            req_d.b  = bus.req_b;
            req_d.op = bus.req_op;
            req_d.rd = bus.req_rd;
            tmo_d    = 1'b0;
          end
        end
        ST_ISSUE: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
        ST_WAIT: begin
          if (bus.mdu_result_vld) begin
            state_d = ST_DONE;
            wdat_d  = bus.mdu_result;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          tmo_d   = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Park the opcode on no-op outside ISSUE/WAIT so a stray
    // mdu_result_vld is masked on the MDU side.
    if (state_d == ST_IDLE || state_d == ST_DONE) begin
      req_d.op = MDU_OP_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      wdat_q  <= wdat_d;
    end
  end

  assign bus.stall = busy | accept;

  assign bus.err_illegal = (state_q == ST_IDLE)
                         & bus.req_vld & ~is_mul
                         & ~bus.flush;

  assign bus.mdu_src_vld = (state_q == ST_ISSUE)
                         & ~bus.flush;

  assign bus.mdu_src_clear = (busy & bus.flush)
                           | (tmo_hit & ~bus.flush);

  assign bus.mdu_op   = req_q.op;
  assign bus.mdu_srcA = req_q.a;
  assign bus.mdu_srcB = req_q.b;

  assign bus.wb_vld = (state_q == ST_DONE)
                    & ~tmo_q & ~bus.flush;

  assign bus.err_timeout = (state_q == ST_DONE)
                         & tmo_q & ~bus.flush;

  assign bus.wb_rd   = req_q.rd;
  assign bus.wb_data = wdat_q;

endmodule

// File: tb/tb_sr_mdu_issue.sv
// Scoreboard bench for sr_mdu_issue with a behavioural MDU.
// Directed MUL, back-to-back, illegal, flush, timeout, reset.
module tb_sr_mdu_issue;

  localparam int LAT = 2;
  localparam int TMO = 16;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  sr_mdu_issue_if ifc();

  sr_mdu_issue #(
    .MUL_LATENCY(LAT),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h",
               name, act, exp);
    end
  endtask

  // Behavioural MDU: fixed latency, optionally never answers.
  bit          drop = 1'b0;
  logic        pend;
  int          iss_cyc;
  logic [31:0] res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= 1'b0;
      iss_cyc <= 0;
      res     <= '0;
    end else if (ifc.mdu_src_clear) begin
      pend <= 1'b0;
    end else if (ifc.mdu_src_vld && !drop) begin
      pend    <= 1'b1;
      iss_cyc <= cyc;
      res     <= ifc.mdu_srcA * ifc.mdu_srcB;
    end else if (ifc.mdu_result_vld) begin
      pend <= 1'b0;
    end
  end

  assign ifc.mdu_result = res;
  assign ifc.mdu_result_vld = pend && (cyc == iss_cyc + LAT)
                            && (ifc.mdu_op == 3'b000);

  // Monitor / scoreboard
  int stall_tot = 0;
  int src_tot = 0;
  int wb_tot = 0;
  int last_src = 0;
  int prev_src = 0;
  int last_wb = 0;
  int last_clr = 0;
  int last_tmo = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    int   k;
    if (ifc.stall) stall_tot++;
    if (ifc.mdu_src_vld) begin
      prev_src = last_src;
      last_src = cyc;
      src_tot++;
    end
    if (ifc.mdu_src_clear) last_clr = cyc;
    if (ifc.wb_vld) begin
      wb_tot++;
      last_wb = cyc;
    end
    if (ifc.err_timeout) last_tmo = cyc;
    if (ifc.wb_vld || ifc.err_timeout || ifc.err_illegal) begin
      k = ifc.wb_vld ? 0 : (ifc.err_timeout ? 1 : 2);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got event kind %0d required none", k);
      end else begin
        e = q.pop_front();
        chk("sb_kind", k, e.kind);
        if (k == 0) begin
          chk("sb_wb_rd", {27'd0, ifc.wb_rd}, {27'd0, e.rd});
          chk("sb_wb_data", ifc.wb_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [4:0] rd,
                      input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.rd   = rd;
    e.data = data;
    q.push_back(e);
  endtask

  // Issue a MUL, hold req_vld while stalled, return in DONE.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input bit tmo, output int t0);
    int n;
    push(tmo ? 1 : 0, rd, exp);
    ifc.req_vld = 1'b1;
    ifc.req_op  = 3'b000;
    ifc.req_a   = a;
    ifc.req_b   = b;
    ifc.req_rd  = rd;
    t0 = cyc;
    n = 0;
    do begin
      step();
      n++;
    end while (ifc.stall && n < 40);
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mul_hang: got stall after %0d cycles required release", n);
    end
    ifc.req_vld = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, ifc.stall}, 0);
    chk({tag, "_wb_vld"}, {31'd0, ifc.wb_vld}, 0);
    chk({tag, "_wb_rd"}, {27'd0, ifc.wb_rd}, 0);
    chk({tag, "_wb_data"}, ifc.wb_data, 0);
    chk({tag, "_err_ill"}, {31'd0, ifc.err_illegal}, 0);
    chk({tag, "_err_tmo"}, {31'd0, ifc.err_timeout}, 0);
    chk({tag, "_srcA"}, ifc.mdu_srcA, 0);
    chk({tag, "_srcB"}, ifc.mdu_srcB, 0);
    chk({tag, "_src_vld"}, {31'd0, ifc.mdu_src_vld}, 0);
    chk({tag, "_src_clr"}, {31'd0, ifc.mdu_src_clear}, 0);
    chk({tag, "_mdu_op"}, {29'd0, ifc.mdu_op}, 0);
  endtask

  initial begin
    int t0, s0, v0, w0, n;
    ifc.req_vld = 1'b0;
    ifc.req_op  = 3'b000;
    ifc.req_a   = '0;
    ifc.req_b   = '0;
    ifc.req_rd  = '0;
    ifc.flush   = 1'b0;
    repeat (3) step();
    chk_zero("rst");
    reset_n = 1'b1;
    step();
    chk("idle_mdu_op", {29'd0, ifc.mdu_op}, 32'd7);
    chk("idle_stall", {31'd0, ifc.stall}, 0);

    // 7 x 6 -> 42, rd 5
    s0 = stall_tot; v0 = src_tot;
    do_mul(32'd7, 32'd6, 5'd5, 32'd42, 1'b0, t0);
    step();
    chk("mul_stall_cycles", stall_tot - s0, 4);
    chk("mul_src_count", src_tot - v0, 1);
    chk("mul_src_time", last_src - t0, 1);
    chk("mul_wb_time", last_wb - t0, 4);

    // back-to-back
    v0 = src_tot;
    do_mul(32'hFFFF_FFFF, 32'd2, 5'd1, 32'hFFFF_FFFE, 1'b0, t0);
    do_mul(32'd3, 32'd3, 5'd2, 32'd9, 1'b0, t0);
    step();
    chk("b2b_src_count", src_tot - v0, 2);
    chk("b2b_src_gap", last_src - prev_src, 5);

    // unsupported opcode
    v0 = src_tot; w0 = wb_tot;
    push(2, 5'd0, 32'd0);
    ifc.req_vld = 1'b1;
    ifc.req_op  = 3'b001;
    ifc.req_rd  = 5'd4;
    #1;
    chk("ill_err", {31'd0, ifc.err_illegal}, 1);
    chk("ill_stall", {31'd0, ifc.stall}, 0);
    step();
    ifc.req_vld = 1'b0;
    ifc.req_op  = 3'b000;
    repeat (3) step();
    chk("ill_no_src", src_tot - v0, 0);
    chk("ill_no_wb", wb_tot - w0, 0);

    // flush coinciding with result
    w0 = wb_tot;
    ifc.req_vld = 1'b1;
    ifc.req_a   = 32'd8;
    ifc.req_b   = 32'd8;
    ifc.req_rd  = 5'd9;
    n = 0;
    while (!ifc.mdu_result_vld && n < 20) begin
      step();
      n++;
    end
    chk("flush_res_delay", n, 3);
    ifc.flush   = 1'b1;
    ifc.req_vld = 1'b0;
    #1;
    chk("flush_src_clr", {31'd0, ifc.mdu_src_clear}, 1);
    chk("flush_wb_vld", {31'd0, ifc.wb_vld}, 0);
    step();
    ifc.flush = 1'b0;
    #1;
    chk("flush_idle_stall", {31'd0, ifc.stall}, 0);
    chk("flush_idle_op", {29'd0, ifc.mdu_op}, 32'd7);
    repeat (3) step();
    chk("flush_no_wb", wb_tot - w0, 0);
    do_mul(32'd3, 32'd4, 5'd7, 32'd12, 1'b0, t0);
    step();

    // timeout
    drop = 1'b1;
    w0 = wb_tot;
    do_mul(32'd2, 32'd2, 5'd6, 32'd0, 1'b1, t0);
    step();
    chk("tmo_clr_time", last_clr - t0, TMO + 1);
    chk("tmo_err_time", last_tmo - t0, TMO + 2);
    chk("tmo_no_wb", wb_tot - w0, 0);
    drop = 1'b0;

    // reset during WAIT
    ifc.req_vld = 1'b1;
    ifc.req_a   = 32'd9;
    ifc.req_b   = 32'd9;
    ifc.req_rd  = 5'd11;
    step();
    step();
    chk("rstw_stall", {31'd0, ifc.stall}, 1);
    ifc.req_vld = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_zero("rstw");
    step();
    reset_n = 1'b1;
    step();
    do_mul(32'd5, 32'd5, 5'd3, 32'd25, 1'b0, t0);
    repeat (3) step();

    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
